// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port front end to a single synchronous data memory.
// Arbitrates ReqA/ReqB (lock hint with a burst limit, else round-robin),
// registers the winning access toward memory and returns read data to the
// winning port two cycles after acceptance.
module dm_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       Reset_n,
  input  logic       ReqA,
  input  logic       ReqB,
  input  logic       WrA,
  input  logic       WrB,
  input  logic [7:0] AddrA,
  input  logic [7:0] AddrB,
  input  logic [7:0] WDataA,
  input  logic [7:0] WDataB,
  input  logic       LockA,
  input  logic       LockB,
  output logic       GntA,
  output logic       GntB,
  output logic       RValidA,
  output logic       RValidB,
  output logic [7:0] RDataA,
  output logic [7:0] RDataB,
  output logic [7:0] DataAddr,
  output logic       MemWrite,
  output logic [7:0] DataIn,
  input  logic [7:0] DataOut,
  output logic       Busy
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);
  localparam logic [CW-1:0] ONE_CNT = CW'(1);

  logic          lastB;      // 1: port B won the most recent grant
  logic [CW-1:0] burstCnt;   // consecutive grants to the last winner
  logic          lastLock;
  logic          lockHold;
  logic          grant;
  logic          winWr;
  logic [7:0]    winAddr;
  logic [7:0]    winData;
  logic          issueVld;   // memory stage holds an access this cycle
  logic          issueRd;    // that access is a read
  logic          issuePortB; // that access belongs to port B

  // Arbitration: lone requester wins; else locked last winner under the burst limit; else round-robin.
  always_comb begin
    GntA     = 1'b0;
    GntB     = 1'b0;
    lockHold = 1'b0;
    lastLock = lastB ? LockB : LockA;
    if (!Reset_n) begin
      GntA = 1'b0;
      GntB = 1'b0;
    end else if (ReqA && ReqB) begin
      lockHold = lastLock && (burstCnt < MAX_CNT);
      if (lockHold) begin
        GntA = !lastB;
        GntB = lastB;
      end else begin
        GntA = lastB;
        GntB = !lastB;
      end
    end else begin
      GntA = ReqA;
      GntB = ReqB;
    end
  end

  // Select the winning port's access fields.
  always_comb begin
    grant   = GntA || GntB;
    winWr   = 1'b0;
    winAddr = 8'h00;
    winData = 8'h00;
    if (GntB) begin
      winWr   = WrB;
      winAddr = AddrB;
      winData = WDataB;
    end else begin
      winWr   = WrA;
      winAddr = AddrA;
      winData = WDataA;
    end
  end

  // Track last winner and burst length; idle cycles leave both untouched.
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      lastB    <= 1'b1;
      burstCnt <= {CW{1'b0}};
    end else if (grant) begin
      lastB <= GntB;
      if (GntB != lastB) begin
        burstCnt <= ONE_CNT;
      end else if (burstCnt < MAX_CNT) begin
        burstCnt <= burstCnt + ONE_CNT;
      end else begin
        burstCnt <= burstCnt;
      end
    end else begin
      lastB    <= lastB;
      burstCnt <= burstCnt;
    end
  end

  // Memory issue stage: capture the accepted access; idle cycles drop MemWrite but hold address/data.
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      DataAddr   <= 8'h00;
      DataIn     <= 8'h00;
      MemWrite   <= 1'b0;
      issueVld   <= 1'b0;
      issueRd    <= 1'b0;
      issuePortB <= 1'b0;
    end else if (grant) begin
      DataAddr   <= winAddr;
      DataIn     <= winData;
      MemWrite   <= winWr;
      issueVld   <= 1'b1;
      issueRd    <= !winWr;
      issuePortB <= GntB;
    end else begin
      DataAddr   <= DataAddr;
      DataIn     <= DataIn;
      MemWrite   <= 1'b0;
      issueVld   <= 1'b0;
      issueRd    <= 1'b0;
      issuePortB <= issuePortB;
    end
  end

  // Read return: memory data arrives the cycle after the issue stage, so flag it to the owning port.
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      RValidA <= 1'b0;
      RValidB <= 1'b0;
    end else begin
      RValidA <= issueVld && issueRd && !issuePortB;
      RValidB <= issueVld && issueRd && issuePortB;
    end
  end

  // Both ports see memory data directly; RValid qualifies it.
  assign RDataA = DataOut;
  assign RDataB = DataOut;
  assign Busy   = issueVld;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a synchronous memory model and a read
// scoreboard (expected read data queued at acceptance, compared on return).
module tb_dm_arbiter;

  logic       clk;
  logic       Reset_n;
  logic       ReqA, ReqB, WrA, WrB, LockA, LockB;
  logic [7:0] AddrA, AddrB, WDataA, WDataB;
  logic       GntA, GntB, RValidA, RValidB, MemWrite, Busy;
  logic [7:0] RDataA, RDataB, DataAddr, DataIn, DataOut;

  typedef struct {
    bit         port;   // 0 = A, 1 = B
    logic [7:0] data;
    int         due;    // cycle number in which RValid must show
  } rd_t;

  rd_t        sbq[$];
  logic [7:0] mem [256];
  logic [7:0] refMem [256];
  bit         memInit = 1'b0;
  bit         monOn = 1'b0;
  int         cyc = 0;
  int         nChecks = 0;
  int         nErrors = 0;
  logic       expMW;
  logic [7:0] expAddr, expDin;
  logic       expBusy;

  dm_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .Reset_n(Reset_n),
    .ReqA(ReqA), .ReqB(ReqB), .WrA(WrA), .WrB(WrB),
    .AddrA(AddrA), .AddrB(AddrB), .WDataA(WDataA), .WDataB(WDataB),
    .LockA(LockA), .LockB(LockB), .GntA(GntA), .GntB(GntB),
    .RValidA(RValidA), .RValidB(RValidB), .RDataA(RDataA), .RDataB(RDataB),
    .DataAddr(DataAddr), .MemWrite(MemWrite), .DataIn(DataIn),
    .DataOut(DataOut), .Busy(Busy)
  );

  function automatic logic [7:0] initVal(input logic [7:0] a);
    case (a)
      8'h00:   return 8'h3C;
      8'h01:   return 8'h74;
      default: return a ^ 8'hA5;
    endcase
  endfunction

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to time read returns.
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory: preload on first edge, then write-enable plus registered read.
  always @(posedge clk) begin
    if (!memInit) begin
      for (int i = 0; i < 256; i++) mem[i] <= initVal(8'(i));
      memInit <= 1'b1;
    end else begin
      if (MemWrite === 1'b1) mem[DataAddr] <= DataIn;
      DataOut <= mem[DataAddr];
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Read-return monitor: a due scoreboard entry must appear on its port, otherwise both RValid low.
  always @(negedge clk) begin
    if (monOn) begin
      if (sbq.size() != 0 && sbq[0].due == cyc) begin
        rd_t e;
        e = sbq.pop_front();
        chk("RValidA", {7'b0, RValidA}, {7'b0, (e.port == 1'b0)});
        chk("RValidB", {7'b0, RValidB}, {7'b0, (e.port == 1'b1)});
        chk(e.port ? "RDataB" : "RDataA", e.port ? RDataB : RDataA, e.data);
      end else begin
        chk("RValid idle", {6'b0, RValidA, RValidB}, 8'h00);
      end
    end
  end

  // One arbitration cycle: check registered stage vs model, check grants, then update the model.
  task automatic cycle(input logic eA, input logic eB, input string tag);
    logic       p, w;
    logic [7:0] a, d;
    @(negedge clk);
    chk({tag, " MemWrite"}, {7'b0, MemWrite}, {7'b0, expMW});
    chk({tag, " DataAddr"}, DataAddr, expAddr);
    chk({tag, " DataIn"}, DataIn, expDin);
    chk({tag, " Busy"}, {7'b0, Busy}, {7'b0, expBusy});
    chk({tag, " GntA"}, {7'b0, GntA}, {7'b0, eA});
    chk({tag, " GntB"}, {7'b0, GntB}, {7'b0, eB});
    if (eA || eB) begin
      p = eB;
      w = eB ? WrB : WrA;
      a = eB ? AddrB : AddrA;
      d = eB ? WDataB : WDataA;
      expMW   = w;
      expAddr = a;
      expDin  = d;
      expBusy = 1'b1;
      if (w) refMem[a] = d;
      else sbq.push_back('{port: p, data: refMem[a], due: cyc + 2});
    end else begin
      expMW   = 1'b0;
      expBusy = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Hold reset for n edges: grants blocked, reads not yet returned are discarded.
  task automatic doReset(input int n);
    Reset_n = 1'b0;
    while (sbq.size() > 0 && sbq[sbq.size() - 1].due > cyc) void'(sbq.pop_back());
    repeat (n) begin
      @(negedge clk);
      chk("rst GntA", {7'b0, GntA}, 8'h00);
      chk("rst GntB", {7'b0, GntB}, 8'h00);
      @(posedge clk);
      #1;
    end
    chk("rst MemWrite", {7'b0, MemWrite}, 8'h00);
    chk("rst DataAddr", DataAddr, 8'h00);
    chk("rst DataIn", DataIn, 8'h00);
    chk("rst Busy", {7'b0, Busy}, 8'h00);
    chk("rst RValid", {6'b0, RValidA, RValidB}, 8'h00);
    Reset_n = 1'b1;
    expMW   = 1'b0;
    expAddr = 8'h00;
    expDin  = 8'h00;
    expBusy = 1'b0;
  endtask

  task automatic setA(input logic req, input logic wr, input logic lock, input logic [7:0] a, input logic [7:0] d);
    ReqA = req; WrA = wr; LockA = lock; AddrA = a; WDataA = d;
  endtask

  task automatic setB(input logic req, input logic wr, input logic lock, input logic [7:0] a, input logic [7:0] d);
    ReqB = req; WrB = wr; LockB = lock; AddrB = a; WDataB = d;
  endtask

  // Directed sequence.
  initial begin
    logic [9:0] lockSeq;
    for (int i = 0; i < 256; i++) refMem[i] = initVal(8'(i));
    Reset_n = 1'b0;
    setA(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    setB(1'b1, 1'b0, 1'b0, 8'h01, 8'h00);
    doReset(2);
    monOn = 1'b1;

    // Simultaneous reads after reset: A first, then B; returns on consecutive cycles.
    setA(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    setB(1'b1, 1'b0, 1'b0, 8'h01, 8'h00);
    cycle(1'b1, 1'b0, "sim A");
    setA(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    cycle(1'b0, 1'b1, "sim B");
    setB(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) cycle(1'b0, 1'b0, "idle1");

    // Read-after-write on consecutive edges.
    setA(1'b1, 1'b1, 1'b0, 8'h10, 8'h5A);
    cycle(1'b1, 1'b0, "raw wr");
    setA(1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
    cycle(1'b1, 1'b0, "raw rd");
    setA(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) cycle(1'b0, 1'b0, "idle2");

    // Locked burst from A against a steady B request, burst limit 4.
    doReset(1);
    lockSeq = 10'b1000010000;   // bit k set: B expected in step k
    for (int k = 0; k < 10; k++) begin
      setA(1'b1, 1'b0, 1'b1, 8'(32'h20 + k), 8'h00);
      setB(1'b1, 1'b0, 1'b0, 8'(32'h40 + k), 8'h00);
      cycle(!lockSeq[k], lockSeq[k], $sformatf("lock%0d", k));
    end
    setA(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    setB(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) cycle(1'b0, 1'b0, "idle3");

    // Lone B writer, no lock: granted every cycle, MemWrite drops once idle.
    for (int k = 0; k < 6; k++) begin
      setB(1'b1, 1'b1, 1'b0, 8'(32'h80 + k), 8'(k * 3 + 1));
      cycle(1'b0, 1'b1, $sformatf("loneB%0d", k));
    end
    setB(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) cycle(1'b0, 1'b0, "idle4");
    setB(1'b1, 1'b0, 1'b0, 8'h82, 8'h00);
    cycle(1'b0, 1'b1, "rdback");
    setB(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) cycle(1'b0, 1'b0, "idle5");

    // Reset right after a read acceptance: the read never returns; A wins first afterwards.
    setA(1'b1, 1'b0, 1'b0, 8'h01, 8'h00);
    cycle(1'b1, 1'b0, "pre-rst");
    setA(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    setB(1'b1, 1'b0, 1'b0, 8'h83, 8'h00);
    doReset(1);
    cycle(1'b1, 1'b0, "post A");
    setA(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    cycle(1'b0, 1'b1, "post B");
    setB(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) cycle(1'b0, 1'b0, "idle6");

    chk("sb empty", 8'(sbq.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
